sti_dac_oem_writer: RTL and testbench

Downstream stage of the serial transmitter in the STI/DAC subsystem. Deserializes the transmitter's serial stream (`so_data`/`so_valid`) into bytes and writes them into the eight 32×8 output-element memories. The memories are organised as four groups, each an odd/even pair, and bytes are placed in a checkerboard pattern. On end of input, it pads all unwritten locations with zero and then raises `oem_finish`.

---
 rtl/sti_dac_oem_writer_pkg.sv | 36 +++
 rtl/sti_dac_oem_writer_if.sv | 28 ++
 rtl/sti_dac_oem_writer_addr_map.sv | 18 +
 rtl/sti_dac_oem_writer.sv | 126 ++++++++++++
 tb/tb_sti_dac_oem_writer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/sti_dac_oem_writer_pkg.sv
// Shared types and geometry for the STI/DAC output-element-memory writer.
// Byte index -> (group, odd/even, word address) checkerboard map lives here.
package sti_dac_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        PAD     = 2'd1,
        DONE    = 2'd2
    } oem_state_e;

    localparam int OEM_BYTES       = 256;
    localparam int OEM_GROUP_BYTES = 64;
    localparam int OEM_ROW_BYTES   = 8;

    typedef struct packed {
        logic [1:0] grp;
        logic       odd;
        logic [4:0] addr;
    } oem_loc_t;

    function automatic oem_loc_t oem_map(input logic [7:0] idx);
        oem_loc_t   loc;
        logic [5:0] m;
        logic [2:0] row;
        logic [2:0] col;
        m        = idx[$clog2(OEM_GROUP_BYTES)-1:0];
        row      = m[5:$clog2(OEM_ROW_BYTES)];
        col      = m[$clog2(OEM_ROW_BYTES)-1:0];
        loc.grp  = idx[7:6];
        // Adjacent bytes alternate memories along both rows and columns
        loc.odd  = row[0] ^ col[0];
        loc.addr = m[5:1];
        return loc;
    endfunction

endpackage

// File: rtl/sti_dac_oem_writer_if.sv
// Serial-in / memory-write-out bundle between the transmitter, this writer and the OEMs.
// No flow control: the writer always accepts serial bits and strobes are fire-and-forget.
interface sti_dac_oem_writer_if;
    logic       so_data;
    logic       so_valid;
    logic       pi_end;
    logic [7:0] oem_dataout;
    logic [4:0] oem_addr;
    logic       odd1_wr, odd2_wr, odd3_wr, odd4_wr;
    logic       even1_wr, even2_wr, even3_wr, even4_wr;
    logic       oem_finish;

    modport slave (
        input  so_data, so_valid, pi_end,
        output oem_dataout, oem_addr,
        output odd1_wr, odd2_wr, odd3_wr, odd4_wr,
        output even1_wr, even2_wr, even3_wr, even4_wr,
        output oem_finish
    );

    modport master (
        output so_data, so_valid, pi_end,
        input  oem_dataout, oem_addr,
        input  odd1_wr, odd2_wr, odd3_wr, odd4_wr,
        input  even1_wr, even2_wr, even3_wr, even4_wr,
        input  oem_finish
    );
endinterface

// File: rtl/sti_dac_oem_writer_addr_map.sv
// Combinational byte-index decode: word address plus one-hot strobe
// {odd4..odd1, even4..even1}; zero latency, no backpressure.
module oem_addr_map
    import sti_dac_pkg::*;
(
    input  logic [7:0] idx_i,
    output logic [4:0] addr_o,
    output logic [7:0] wr_o
);
    oem_loc_t loc;

    always_comb begin
        loc              = oem_map(idx_i);
        addr_o           = loc.addr;
        wr_o             = 8'd0;
        wr_o[{loc.odd, loc.grp}] = 1'b1;
    end
endmodule

// File: rtl/sti_dac_oem_writer.sv
// Deserialises the transmitter bit stream into the eight OEMs, then zero-pads to 256 bytes.
// Writes appear one cycle after the completing bit / pi_end; input is never backpressured.
module sti_dac_oem_writer
    import sti_dac_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    sti_dac_oem_writer_if.slave   bus
);
    oem_state_e state_q, state_d;
    logic [8:0] n_q, n_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic [7:0] sh_q, sh_d;
    logic [7:0] wr_q, wr_d;
    logic [7:0] dat_q, dat_d;
    logic [4:0] addr_q, addr_d;
    logic       fin_q, fin_d;

    logic [4:0] map_addr;
    logic [7:0] map_wr;
    logic [7:0] sh_nx;
    logic [3:0] cnt_nx;
    logic       do_wr;
    logic [7:0] wr_byte;

    oem_addr_map u_map (
        .idx_i  (n_q[7:0]),
        .addr_o (map_addr),
        .wr_o   (map_wr)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        bcnt_d  = bcnt_q;
        sh_d    = sh_q;
        wr_d    = 8'd0;
        dat_d   = dat_q;
        addr_d  = addr_q;
        fin_d   = (state_q == DONE);
        sh_nx   = sh_q;
        cnt_nx  = {1'b0, bcnt_q};
        do_wr   = 1'b0;
        wr_byte = 8'd0;

        case (state_q)
            COLLECT: begin
                if (bus.so_valid) begin
                    sh_nx  = {sh_q[6:0], bus.so_data};
                    cnt_nx = cnt_nx + 4'd1;
                end
                // A bit arriving with pi_end is captured before the end is handled
                if (cnt_nx == 4'd8) begin
                    do_wr   = 1'b1;
                    wr_byte = sh_nx;
                    cnt_nx  = 4'd0;
                end else if (bus.pi_end && cnt_nx != 4'd0) begin
                    do_wr   = 1'b1;
                    wr_byte = sh_nx << (4'd8 - cnt_nx);
                    cnt_nx  = 4'd0;
                end
                sh_d   = sh_nx;
                bcnt_d = cnt_nx[2:0];
                if (do_wr) begin
                    n_d = n_q + 9'd1;
                end
                if (n_d == 9'(OEM_BYTES)) begin
                    state_d = DONE;
                end else if (bus.pi_end) begin
                    state_d = PAD;
                end
            end
            PAD: begin
                do_wr   = 1'b1;
                wr_byte = 8'd0;
                n_d     = n_q + 9'd1;
                if (n_q == 9'(OEM_BYTES - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
            end
            default: state_d = COLLECT;
        endcase

        if (do_wr) begin
            wr_d   = map_wr;
            dat_d  = wr_byte;
            addr_d = map_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= COLLECT;
            n_q     <= 9'd0;
            bcnt_q  <= 3'd0;
            sh_q    <= 8'd0;
            wr_q    <= 8'd0;
            dat_q   <= 8'd0;
            addr_q  <= 5'd0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            bcnt_q  <= bcnt_d;
            sh_q    <= sh_d;
            wr_q    <= wr_d;
            dat_q   <= dat_d;
            addr_q  <= addr_d;
            fin_q   <= fin_d;
        end
    end

    assign bus.oem_dataout = dat_q;
    assign bus.oem_addr    = addr_q;
    assign bus.even1_wr    = wr_q[0];
    assign bus.even2_wr    = wr_q[1];
    assign bus.even3_wr    = wr_q[2];
    assign bus.even4_wr    = wr_q[3];
    assign bus.odd1_wr     = wr_q[4];
    assign bus.odd2_wr     = wr_q[5];
    assign bus.odd3_wr     = wr_q[6];
    assign bus.odd4_wr     = wr_q[7];
    assign bus.oem_finish  = fin_q;
endmodule

// File: tb/tb_sti_dac_oem_writer.sv
// Scoreboard bench for sti_dac_oem_writer: expected writes are queued with their cycle
// as stimulus is driven and matched against strobes observed on the falling edge.
module tb_sti_dac_oem_writer;
    logic clk = 1'b0;
    logic reset = 1'b1;

    sti_dac_oem_writer_if bus();

    sti_dac_oem_writer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_wr_cyc = -10;
    logic fin_prev = 1'b0;

    typedef struct {
        int         idx;
        logic [7:0] dat;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    logic [7:0] strb;
    assign strb = {bus.odd4_wr, bus.odd3_wr, bus.odd2_wr, bus.odd1_wr,
                   bus.even4_wr, bus.even3_wr, bus.even2_wr, bus.even1_wr};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_strb(input int idx);
        int g, r, c, p;
        logic [7:0] v;
        g = idx / 64;
        r = (idx % 64) / 8;
        c = idx % 8;
        p = (r ^ c) & 1;
        v = 8'h01;
        return v << (p * 4 + g);
    endfunction

    function automatic logic [4:0] exp_addr(input int idx);
        return 5'((idx % 64) / 2);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if ((|strb) === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_wr", strb, 0);
            end else begin
                e = sb.pop_front();
                check($sformatf("strb[%0d]", e.idx), strb, exp_strb(e.idx));
                check($sformatf("addr[%0d]", e.idx), bus.oem_addr, exp_addr(e.idx));
                check($sformatf("data[%0d]", e.idx), bus.oem_dataout, e.dat);
                check($sformatf("cyc[%0d]", e.idx), cyc, e.cyc);
            end
            last_wr_cyc = cyc;
        end
        if (bus.oem_finish === 1'b1 && fin_prev !== 1'b1 && !reset)
            check("finish_lat", cyc, last_wr_cyc + 1);
        fin_prev = bus.oem_finish;
    end

    task automatic send_bit(input logic b, input logic end_p);
        bus.so_valid = 1'b1;
        bus.so_data  = b;
        bus.pi_end   = end_p;
        @(posedge clk);
        #1;
        bus.so_valid = 1'b0;
        bus.so_data  = 1'b0;
        bus.pi_end   = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input int idx);
        for (int i = 7; i >= 0; i--) send_bit(d[i], 1'b0);
        sb.push_back('{idx, d, cyc});
    endtask

    task automatic pulse_end(output int e_cyc);
        bus.pi_end = 1'b1;
        @(posedge clk);
        #1;
        bus.pi_end = 1'b0;
        e_cyc = cyc;
    endtask

    task automatic push_pad(input int from, input int first_cyc);
        for (int i = from; i < 256; i++) sb.push_back('{i, 8'h00, first_cyc + (i - from)});
    endtask

    task automatic do_reset();
        bus.so_valid = 1'b0;
        bus.so_data  = 1'b0;
        bus.pi_end   = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while ((sb.size() != 0 || bus.oem_finish !== 1'b1) && k < limit) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("done_in_budget", (k < limit), 1);
        check("finish_high", bus.oem_finish, 1);
        check("sb_empty", sb.size(), 0);
        repeat (10) @(posedge clk);
        #1;
        check("finish_sticky", bus.oem_finish, 1);
    endtask

    initial begin
        int e;
        logic [7:0] d;
        bus.so_valid = 1'b0;
        bus.so_data  = 1'b0;
        bus.pi_end   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_strb", strb, 0);
        check("rst_data", bus.oem_dataout, 0);
        check("rst_addr", bus.oem_addr, 0);
        check("rst_finish", bus.oem_finish, 0);
        reset = 1'b0;

        // Single byte then early end after three bytes
        send_byte(8'hA5, 0);
        send_byte(8'h5A, 1);
        send_byte(8'hC3, 2);
        repeat (3) @(posedge clk);
        #1;
        pulse_end(e);
        push_pad(3, e + 1);
        wait_done(400);
        send_byte(8'hFF, 0);
        sb.delete();
        pulse_end(e);
        repeat (4) @(posedge clk);
        #1;

        // Partial byte 10110 flushed as 0xB0; serial bits during PAD ignored
        do_reset();
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        pulse_end(e);
        sb.push_back('{0, 8'hB0, e});
        push_pad(1, e + 1);
        for (int i = 0; i < 30; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        wait_done(400);

        // Eighth bit coinciding with pi_end
        do_reset();
        d = 8'h96;
        for (int i = 7; i >= 1; i--) send_bit(d[i], 1'b0);
        send_bit(d[0], 1'b1);
        e = cyc;
        sb.push_back('{0, 8'h96, e});
        push_pad(1, e + 1);
        wait_done(400);

        // Reset in the middle of byte 2
        do_reset();
        send_byte(8'h11, 0);
        send_byte(8'h22, 1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_strb", strb, 0);
        check("mid_rst_data", bus.oem_dataout, 0);
        check("mid_rst_addr", bus.oem_addr, 0);
        check("mid_rst_finish", bus.oem_finish, 0);
        reset = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        check("post_rst_strb", strb, 0);
        send_byte(8'h3C, 0);
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_drain", sb.size(), 0);

        // Full 256-byte stream with no pi_end; trailing bits and pi_end are ignored
        do_reset();
        for (int i = 0; i < 256; i++) begin
            d = (i < 16) ? 8'(i) : 8'($urandom_range(0, 255));
            send_byte(d, i);
        end
        for (int i = 0; i < 16; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        pulse_end(e);
        wait_done(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end
endmodule
